seq_arith_8b_sla: RTL and testbench

Iterative 8-bit arithmetic left shifter with overflow detection and optional saturation; the left-shift counterpart to the combinational arithmetic right shifter. It accepts one operand/amount pair over a val/rdy handshake and shifts one bit position per cycle. It returns the result and a sticky overflow flag over a second val/rdy handshake. It sits in the multi-cycle arithmetic unit beside the combinational shifters, where a single-bit-per-cycle datapath is cheaper than a barrel shifter.

---
 rtl/seq_arith_pkg.sv | 32 +++
 rtl/seq_arith_8b_sla_if.sv | 26 ++
 rtl/seq_arith_8b_sla_dpath.sv | 79 +++++++
 rtl/seq_arith_8b_sla.sv | 84 ++++++++
 tb/tb_seq_arith_8b_sla.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/seq_arith_pkg.sv
// Shared types and constants for the iterative 8-bit arithmetic left shifter.
//   state_e      : control FSM states
//   SAT_POS/NEG  : clamp values used when a shift overflows with saturation on
//   sat_value()  : picks the clamp value from the original operand sign
//   ovf_bit()    : signed-overflow indicator for a single left shift
package seq_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] SAT_POS = 8'h7F;
  localparam logic [7:0] SAT_NEG = 8'h80;

  function automatic logic [7:0] sat_value(input logic sign);
    logic [7:0] v;
    if (sign) begin
      v = SAT_NEG;
    end else begin
      v = SAT_POS;
    end
    return v;
  endfunction

  // A one-bit left shift changes the sign exactly when the top two bits differ.
  function automatic logic ovf_bit(input logic [7:0] v);
    return v[7] ^ v[6];
  endfunction

endpackage

// File: rtl/seq_arith_8b_sla_if.sv
// Request/response bundle of the iterative arithmetic left shifter.
//   in_val/in_rdy  : request handshake, carrying in_ (operand) and amt (0-7)
//   out_val/out_rdy: response handshake, carrying out (result) and ovf
// master = requester/consumer side, slave = shifter side.
interface seq_arith_8b_sla_if;

  logic       in_val;
  logic       in_rdy;
  logic [7:0] in_;
  logic [2:0] amt;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out;
  logic       ovf;

  modport master (
    output in_val, in_, amt, out_rdy,
    input  in_rdy, out_val, out, ovf
  );

  modport slave (
    input  in_val, in_, amt, out_rdy,
    output in_rdy, out_val, out, ovf
  );

endinterface

// File: rtl/seq_arith_8b_sla_dpath.sv
// Datapath of the iterative arithmetic left shifter: shift register,
// down-counter, original-sign bit, sticky overflow and the saturation mux.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : capture in_/amt and start a new transaction
//   shift_en     : perform one left shift and decrement the counter
//   in_, amt     : operand and shift amount
//   cnt_zero     : remaining shift count is zero
//   out, ovf     : result (saturated if enabled) and sticky overflow
module seq_arith_8b_sla_dpath
  import seq_arith_pkg::*;
#(
  parameter bit SATURATE = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       shift_en,
  input  logic [7:0] in_,
  input  logic [2:0] amt,
  output logic       cnt_zero,
  output logic [7:0] out,
  output logic       ovf
);

  logic [7:0] shreg_q, shreg_d;
  logic [2:0] cnt_q,   cnt_d;
  logic       sign_q,  sign_d;
  logic       ovf_q,   ovf_d;

  // Next-state logic for all datapath registers.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    if (load) begin
      shreg_d = in_;
      cnt_d   = amt;
      sign_d  = in_[7];
      ovf_d   = 1'b0;
    end else if (shift_en) begin
      // Overflow is judged on the bits before this shift, never on the result.
      ovf_d   = ovf_q | ovf_bit(shreg_q);
      shreg_d = {shreg_q[6:0], 1'b0};
      cnt_d   = cnt_q - 3'd1;
    end else begin
      shreg_d = shreg_q;
    end
  end

  // Datapath registers, cleared asynchronously so a reset aborts any shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= 8'h00;
      cnt_q   <= 3'd0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cnt_zero = (cnt_q == 3'd0);
  assign ovf      = ovf_q;

  // Result mux: clamp toward the original sign when saturation is enabled.
  always_comb begin
    out = shreg_q;
    if (SATURATE && ovf_q) begin
      out = sat_value(sign_q);
    end else begin
      out = shreg_q;
    end
  end

endmodule

// File: rtl/seq_arith_8b_sla.sv
// Iterative 8-bit arithmetic left shifter with overflow detection and
// optional saturation; shifts one bit per cycle.
//   SATURATE : 1 clamps an overflowed result to 0x7F / 0x80
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset, aborts any transaction
//   bus      : slave side of seq_arith_8b_sla_if (request and response)
// Handshake outputs depend only on the state register.
module seq_arith_8b_sla
  import seq_arith_pkg::*;
#(
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  seq_arith_8b_sla_if.slave   bus
);

  state_e state_q, state_d;
  logic   load_s;
  logic   shift_en_s;
  logic   cnt_zero_s;

  // FSM next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    load_s     = 1'b0;
    shift_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_val) begin
          load_s  = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // A zero count ends the calculation without a further shift.
        if (cnt_zero_s) begin
          state_d = DONE;
        end else begin
          shift_en_s = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_rdy) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.in_rdy  = (state_q == IDLE);
  assign bus.out_val = (state_q == DONE);

  seq_arith_8b_sla_dpath #(
    .SATURATE (SATURATE)
  ) u_dpath (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load_s),
    .shift_en (shift_en_s),
    .in_      (bus.in_),
    .amt      (bus.amt),
    .cnt_zero (cnt_zero_s),
    .out      (bus.out),
    .ovf      (bus.ovf)
  );

endmodule

// File: tb/tb_seq_arith_8b_sla.sv
// Directed bench for seq_arith_8b_sla: one instance without and one with
// saturation, driven with identical stimulus and checked against
// hand-computed results.
module tb_seq_arith_8b_sla;

  logic       clk;
  logic       reset_n;
  logic       in_val;
  logic [7:0] in_;
  logic [2:0] amt;
  logic       out_rdy;

  int total;
  int bad;

  seq_arith_8b_sla_if if_a ();
  seq_arith_8b_sla_if if_b ();

  assign if_a.in_val  = in_val;
  assign if_a.in_     = in_;
  assign if_a.amt     = amt;
  assign if_a.out_rdy = out_rdy;
  assign if_b.in_val  = in_val;
  assign if_b.in_     = in_;
  assign if_b.amt     = amt;
  assign if_b.out_rdy = out_rdy;

  seq_arith_8b_sla #(.SATURATE(1'b0)) dut_raw (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_a)
  );

  seq_arith_8b_sla #(.SATURATE(1'b1)) dut_sat (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_b)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction through both instances; optionally holds off the
  // consumer for 5 cycles and pulses a stray request meanwhile.
  task automatic run_txn(input string tag, input logic [7:0] din, input logic [2:0] dam,
                         input logic [7:0] exp_raw, input logic [7:0] exp_sat,
                         input logic exp_ovf, input bit hold);
    int edges;
    chk({tag, "_idle_rdy"}, 16'(if_a.in_rdy), 16'd1);
    @(negedge clk);
    in_val  = 1'b1;
    in_     = din;
    amt     = dam;
    out_rdy = !hold;
    @(posedge clk);
    #1;
    in_val = 1'b0;
    in_    = 8'hA5;
    amt    = 3'd5;
    chk({tag, "_busy_rdy"}, 16'(if_a.in_rdy), 16'd0);
    edges = 1;
    if (!if_a.out_val) begin
      edges = 0;
      while (!if_a.out_val && edges < 16) begin
        @(posedge clk);
        #1;
        edges++;
      end
    end
    chk({tag, "_latency"}, 16'(edges), 16'(dam) + 16'd1);
    chk({tag, "_out_raw"}, 16'(if_a.out), 16'(exp_raw));
    chk({tag, "_ovf_raw"}, 16'(if_a.ovf), 16'(exp_ovf));
    chk({tag, "_val_sat"}, 16'(if_b.out_val), 16'd1);
    chk({tag, "_out_sat"}, 16'(if_b.out), 16'(exp_sat));
    chk({tag, "_ovf_sat"}, 16'(if_b.ovf), 16'(exp_ovf));
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        in_val = (i == 2);
        in_    = 8'h11;
        amt    = 3'd1;
        @(posedge clk);
        #1;
        chk({tag, "_hold_val"}, 16'(if_a.out_val), 16'd1);
        chk({tag, "_hold_rdy"}, 16'(if_a.in_rdy), 16'd0);
        chk({tag, "_hold_out"}, 16'(if_a.out), 16'(exp_raw));
        chk({tag, "_hold_ovf"}, 16'(if_a.ovf), 16'(exp_ovf));
        chk({tag, "_hold_sat"}, 16'(if_b.out), 16'(exp_sat));
      end
      @(negedge clk);
      in_val  = 1'b0;
      out_rdy = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, "_rdy_back"}, 16'(if_a.in_rdy), 16'd1);
    chk({tag, "_val_drop"}, 16'(if_a.out_val), 16'd0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    in_val  = 1'b0;
    in_     = 8'h00;
    amt     = 3'd0;
    out_rdy = 1'b1;
    #3;
    chk("rst_in_rdy", 16'(if_a.in_rdy), 16'd1);
    chk("rst_out_val", 16'(if_a.out_val), 16'd0);
    chk("rst_out", 16'(if_a.out), 16'h00);
    chk("rst_ovf", 16'(if_a.ovf), 16'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_txn("t05", 8'h05, 3'd2, 8'h14, 8'h14, 1'b0, 1'b0);
    run_txn("tf0", 8'hF0, 3'd3, 8'h80, 8'h80, 1'b0, 1'b0);
    run_txn("t40", 8'h40, 3'd1, 8'h80, 8'h7F, 1'b1, 1'b0);
    run_txn("tb0", 8'hB0, 3'd2, 8'hC0, 8'h80, 1'b1, 1'b0);
    run_txn("t9c", 8'h9C, 3'd0, 8'h9C, 8'h9C, 1'b0, 1'b0);
    run_txn("t01", 8'h01, 3'd7, 8'h80, 8'h7F, 1'b1, 1'b0);
    run_txn("bp",  8'h40, 3'd1, 8'h80, 8'h7F, 1'b1, 1'b1);
    // The stray request during backpressure must not have started anything.
    run_txn("post", 8'h21, 3'd1, 8'h42, 8'h42, 1'b0, 1'b0);

    // Reset in the middle of a long shift.
    @(negedge clk);
    in_val  = 1'b1;
    in_     = 8'h7F;
    amt     = 3'd6;
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    in_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_calc_busy", 16'(if_a.in_rdy), 16'd0);
    reset_n = 1'b0;
    #1;
    chk("abort_out_val", 16'(if_a.out_val), 16'd0);
    chk("abort_in_rdy", 16'(if_a.in_rdy), 16'd1);
    chk("abort_out", 16'(if_a.out), 16'h00);
    chk("abort_ovf", 16'(if_a.ovf), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_txn("t03", 8'h03, 3'd1, 8'h06, 8'h06, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
